// File: rtl/vpu_pipe.sv
// vpu_pipe: pipelined multi-lane vector unit between the systolic array and the
// unified buffer. The stages are bias, leaky ReLU, loss gradient and leaky-ReLU
// derivative, and each beat chooses which of them are enabled. A disabled stage
// still registers its value, so the latency is always 5 register levels.
// Defining VPU_PIPE_H_CACHE_EN adds the H cache FIFO with its count and its
// sticky overflow/underflow flags.
module vpu_pipe #(
    parameter int LANES   = 2,
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int H_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [3:0]                  in_pathway,
    input  logic                        in_h_sel,
    input  logic [LANES*DATA_W-1:0]     in_data,
    input  logic [LANES*DATA_W-1:0]     in_bias,
    input  logic [LANES*DATA_W-1:0]     in_y,
    input  logic [LANES*DATA_W-1:0]     in_h,
    input  logic [DATA_W-1:0]           leak_factor,
    input  logic [DATA_W-1:0]           inv_batch_x2,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_W-1:0]     out_data,
    output logic [$clog2(H_DEPTH):0]    h_cache_count,
    output logic                        h_cache_ovf,
    output logic                        h_cache_unf,
    input  logic                        flag_clr
);

    localparam int PW = 2 * DATA_W;

    typedef logic [LANES-1:0][DATA_W-1:0] vec_t;

    // Clamp a wide signed value into the DATA_W range.
    function automatic logic [DATA_W-1:0] f_sat(input logic signed [PW:0] v);
        logic signed [PW:0] maxv;
        logic signed [PW:0] minv;
        maxv = {{(PW-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
        minv = {{(PW-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
        if (v > maxv)      f_sat = maxv[DATA_W-1:0];
        else if (v < minv) f_sat = minv[DATA_W-1:0];
        else               f_sat = v[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] f_add(input logic signed [DATA_W-1:0] a,
                                                input logic signed [DATA_W-1:0] b);
        logic signed [PW:0] ea;
        logic signed [PW:0] eb;
        ea = a;
        eb = b;
        f_add = f_sat(ea + eb);
    endfunction

    function automatic logic [DATA_W-1:0] f_sub(input logic signed [DATA_W-1:0] a,
                                                input logic signed [DATA_W-1:0] b);
        logic signed [PW:0] ea;
        logic signed [PW:0] eb;
        ea = a;
        eb = b;
        f_sub = f_sat(ea - eb);
    endfunction

    // The product is kept at full width, then shifted down arithmetically (floor).
    function automatic logic [DATA_W-1:0] f_mulsh(input logic signed [DATA_W-1:0] a,
                                                  input logic signed [DATA_W-1:0] b);
        logic signed [PW-1:0] p;
        logic signed [PW:0]   e;
        p = a * b;
        e = p;
        f_mulsh = f_sat(e >>> FRAC_W);
    endfunction

    vec_t w_in, w_bias, w_hs;
    vec_t w_s1_d, w_s2_d, w_s3_d, w_s4_d;
    logic w_adv;

    logic              r_s1_v, r_s2_v, r_s3_v, r_s4_v, r_out_v;
    logic [3:0]        r_s1_path, r_s2_path;
    logic [1:0]        r_s3_path;
    vec_t              r_s1_d, r_s2_d, r_s3_d, r_s4_d, r_out_d;
    vec_t              r_s1_y, r_s2_y;
    vec_t              r_s1_hs, r_s2_hs, r_s3_hs, r_s3_hf;
    logic [DATA_W-1:0] r_s1_leak, r_s2_leak, r_s3_leak;
    logic [DATA_W-1:0] r_s1_inv, r_s2_inv;

    assign w_in     = in_data;
    assign w_bias   = in_bias;
    assign w_adv    = out_ready | ~r_out_v;
    assign in_ready = rst & w_adv;
    assign out_valid = r_out_v;
    assign out_data  = r_out_d;

    // Per-lane datapath of each stage. A stage whose enable bit is clear passes its value through.
    always_comb begin
        logic [DATA_W-1:0] v_h;
        v_h    = '0;
        w_s1_d = '0;
        w_s2_d = '0;
        w_s3_d = '0;
        w_s4_d = '0;
        for (int l = 0; l < LANES; l++) begin
            w_s1_d[l] = in_pathway[3] ? f_add(w_in[l], w_bias[l]) : w_in[l];
            w_s2_d[l] = (r_s1_path[2] && r_s1_d[l][DATA_W-1]) ? f_mulsh(r_s1_d[l], r_s1_leak)
                                                              : r_s1_d[l];
            w_s3_d[l] = r_s2_path[1] ? f_mulsh(f_sub(r_s2_d[l], r_s2_y[l]), r_s2_inv)
                                     : r_s2_d[l];
            // With the loss stage on, the derivative uses this beat's own activation.
            v_h = r_s3_path[1] ? r_s3_hf[l] : r_s3_hs[l];
            w_s4_d[l] = (r_s3_path[0] && (v_h[DATA_W-1] || (v_h == '0)))
                        ? f_mulsh(r_s3_d[l], r_s3_leak) : r_s3_d[l];
        end
    end

    // Pipeline registers. Every stage, including the bubbles, moves together on an advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_v <= 1'b0; r_s2_v <= 1'b0; r_s3_v <= 1'b0; r_s4_v <= 1'b0; r_out_v <= 1'b0;
            r_s1_path <= '0; r_s2_path <= '0; r_s3_path <= '0;
            r_s1_d <= '0; r_s2_d <= '0; r_s3_d <= '0; r_s4_d <= '0; r_out_d <= '0;
            r_s1_y <= '0; r_s2_y <= '0;
            r_s1_hs <= '0; r_s2_hs <= '0; r_s3_hs <= '0; r_s3_hf <= '0;
            r_s1_leak <= '0; r_s2_leak <= '0; r_s3_leak <= '0;
            r_s1_inv <= '0; r_s2_inv <= '0;
        end else if (w_adv) begin
            r_s1_v    <= in_valid;
            r_s1_path <= in_pathway;
            r_s1_d    <= w_s1_d;
            r_s1_y    <= in_y;
            r_s1_hs   <= w_hs;
            r_s1_leak <= leak_factor;
            r_s1_inv  <= inv_batch_x2;

            r_s2_v    <= r_s1_v;
            r_s2_path <= r_s1_path;
            r_s2_d    <= w_s2_d;
            r_s2_y    <= r_s1_y;
            r_s2_hs   <= r_s1_hs;
            r_s2_leak <= r_s1_leak;
            r_s2_inv  <= r_s1_inv;

            r_s3_v    <= r_s2_v;
            r_s3_path <= r_s2_path[1:0];
            r_s3_d    <= w_s3_d;
            r_s3_hs   <= r_s2_hs;
            r_s3_hf   <= r_s2_d;
            r_s3_leak <= r_s2_leak;

            r_s4_v    <= r_s3_v;
            r_s4_d    <= w_s4_d;

            r_out_v   <= r_s4_v;
            r_out_d   <= r_s4_d;
        end
    end

`ifdef VPU_PIPE_H_CACHE_EN
    localparam int AW = $clog2(H_DEPTH);
    localparam int CW = AW + 1;

    vec_t           r_mem [H_DEPTH];
    logic [AW-1:0]  r_wr, r_rd;
    logic [CW-1:0]  r_cnt;
    logic           r_ovf, r_unf;
    logic           w_pop, w_push, w_empty, w_full, w_pop_ok, w_push_ok;

    assign w_pop     = in_valid & in_ready & in_h_sel & ~in_pathway[1];
    assign w_push    = w_adv & r_s2_v & (r_s2_path == 4'b1111);
    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == CW'(H_DEPTH));
    assign w_pop_ok  = w_pop & ~w_empty;
    // A pop in the same cycle frees a slot, so a full cache still accepts the push.
    assign w_push_ok = w_push & (~w_full | w_pop_ok);

    assign h_cache_count = r_cnt;
    assign h_cache_ovf   = r_ovf;
    assign h_cache_unf   = r_unf;

    // Sideband H comes from the cache on a pop (zero on underflow), otherwise from the buffer.
    always_comb begin
        w_hs = in_h;
        if (w_pop) begin
            w_hs = w_empty ? '0 : r_mem[r_rd];
        end
    end

    // Cache storage needs no reset: the pointers and the count define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr] <= r_s2_d;
        end
    end

    // Pointers, occupancy and sticky flags. A new event wins over flag_clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + AW'(1);
            if (w_pop_ok)  r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + CW'(w_push_ok) - CW'(w_pop_ok);
            r_ovf <= (r_ovf & ~flag_clr) | (w_push & ~w_push_ok);
            r_unf <= (r_unf & ~flag_clr) | (w_pop & w_empty);
        end
    end
`else
    logic w_unused;

    assign w_hs          = in_h;
    assign h_cache_count = '0;
    assign h_cache_ovf   = 1'b0;
    assign h_cache_unf   = 1'b0;
    assign w_unused      = ^{in_h_sel, r_s2_path};
`endif

endmodule

// File: tb/tb_vpu_pipe.sv
// Self-checking bench for vpu_pipe. It runs directed scenarios and then a
// randomized phase. Expected results come from a behavioural model that works
// on whole beats with plain integer arithmetic and a queue-based H cache.
module tb_vpu_pipe;
    localparam int LANES   = 2;
    localparam int DATA_W  = 16;
    localparam int FRAC_W  = 8;
    localparam int H_DEPTH = 8;
    localparam int W       = LANES * DATA_W;
`ifdef VPU_PIPE_H_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic                    clk, rst;
    logic                    in_valid, in_ready, in_h_sel;
    logic [3:0]              in_pathway;
    logic [W-1:0]            in_data, in_bias, in_y, in_h;
    logic [DATA_W-1:0]       leak_factor, inv_batch_x2;
    logic                    out_valid, out_ready;
    logic [W-1:0]            out_data;
    logic [$clog2(H_DEPTH):0] h_cache_count;
    logic                    h_cache_ovf, h_cache_unf, flag_clr;

    vpu_pipe #(.LANES(LANES), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .H_DEPTH(H_DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pathway(in_pathway), .in_h_sel(in_h_sel), .in_data(in_data),
        .in_bias(in_bias), .in_y(in_y), .in_h(in_h), .leak_factor(leak_factor),
        .inv_batch_x2(inv_batch_x2), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .h_cache_count(h_cache_count), .h_cache_ovf(h_cache_ovf),
        .h_cache_unf(h_cache_unf), .flag_clr(flag_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int due; logic [W-1:0] d; } pend_t;
    logic [W-1:0] sb[$];     // expected output beats, in order
    logic [W-1:0] mc[$];     // model H cache
    pend_t        pq[$];     // cache writes still travelling towards S2
    int           adv_cnt = 0;
    bit           m_ovf = 1'b0, m_unf = 1'b0;
    bit           last_acc;
    int           n_out = 0, n_acc = 0;

    function automatic longint m_sat(input longint v);
        longint lim;
        lim = longint'(1) << (DATA_W - 1);
        if (v > lim - 1) return lim - 1;
        if (v < -lim) return -lim;
        return v;
    endfunction

    function automatic longint m_mul(input longint a, input longint b);
        return m_sat((a * b) >>> FRAC_W);
    endfunction

    function automatic longint m_lane(input logic [W-1:0] v, input int l);
        logic [DATA_W-1:0] s;
        s = v[l*DATA_W +: DATA_W];
        return longint'($signed(s));
    endfunction

    function automatic void ref_beat(input logic [W-1:0] x, input logic [W-1:0] b,
                                     input logic [W-1:0] y, input logic [W-1:0] hs,
                                     input logic [3:0] p, input logic [DATA_W-1:0] lk,
                                     input logic [DATA_W-1:0] iv,
                                     output logic [W-1:0] res, output logic [W-1:0] h2);
        longint v, h, hh, lkv, ivv;
        lkv = longint'($signed(lk));
        ivv = longint'($signed(iv));
        res = '0;
        h2  = '0;
        for (int l = 0; l < LANES; l++) begin
            v = m_lane(x, l);
            if (p[3]) v = m_sat(v + m_lane(b, l));
            if (p[2] && v < 0) v = m_mul(v, lkv);
            h = v;
            h2[l*DATA_W +: DATA_W] = DATA_W'(h);
            if (p[1]) v = m_mul(m_sat(v - m_lane(y, l)), ivv);
            hh = p[1] ? h : m_lane(hs, l);
            if (p[0] && hh <= 0) v = m_mul(v, lkv);
            res[l*DATA_W +: DATA_W] = DATA_W'(v);
        end
    endfunction

    function automatic void model_reset();
        n_acc -= sb.size();
        sb.delete();
        mc.delete();
        pq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    // One clock: sample the handshakes before the edge, update the model, then check the cache state after the edge.
    task automatic tick();
        bit adv, acc, ohs, ovf_e, unf_e;
        logic [W-1:0] hs, res, h2, e;
        pend_t pe;
        #2;
        adv = in_ready;
        acc = in_valid && adv;
        ohs = out_valid && out_ready;
        ovf_e = 1'b0;
        unf_e = 1'b0;
        if (ohs) begin
            n_out++;
            if (sb.size() == 0) chk("spurious_out", out_valid, 1'b0);
            else begin
                e = sb.pop_front();
                chk("out_data", out_data, e);
            end
        end
        if (adv) begin
            hs = in_h;
            if (CACHE && acc && in_h_sel && !in_pathway[1]) begin
                if (mc.size() > 0) hs = mc.pop_front();
                else begin
                    hs = '0;
                    unf_e = 1'b1;
                end
            end
            if (acc) begin
                ref_beat(in_data, in_bias, in_y, hs, in_pathway, leak_factor, inv_batch_x2, res, h2);
                sb.push_back(res);
                n_acc++;
            end
            if (pq.size() > 0 && pq[0].due == adv_cnt) begin
                pe = pq.pop_front();
                if (mc.size() < H_DEPTH) mc.push_back(pe.d);
                else ovf_e = 1'b1;
            end
            if (CACHE && acc && in_pathway == 4'hF) begin
                pe.due = adv_cnt + 2;
                pe.d   = h2;
                pq.push_back(pe);
            end
            adv_cnt++;
        end
        m_ovf = (m_ovf && !flag_clr) || ovf_e;
        m_unf = (m_unf && !flag_clr) || unf_e;
        last_acc = acc;
        @(posedge clk);
        #1;
        chk("cache_count", h_cache_count, mc.size());
        chk("ovf_flag", h_cache_ovf, m_ovf);
        chk("unf_flag", h_cache_unf, m_unf);
    endtask

    task automatic drive(input logic v, input logic [3:0] p, input logic hsel,
                         input logic [W-1:0] x, input logic [W-1:0] b,
                         input logic [W-1:0] y, input logic [W-1:0] h);
        in_valid = v; in_pathway = p; in_h_sel = hsel;
        in_data = x; in_bias = b; in_y = y; in_h = h;
    endtask

    task automatic send(input logic [3:0] p, input logic hsel, input logic [W-1:0] x,
                        input logic [W-1:0] b, input logic [W-1:0] y, input logic [W-1:0] h);
        int g;
        g = 0;
        drive(1'b1, p, hsel, x, b, y, h);
        last_acc = 1'b0;
        while (!last_acc && g < 50) begin
            tick();
            g++;
        end
        if (!last_acc) chk("send_timeout", last_acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!out_valid) chk("out_timeout", out_valid, 1'b1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int lat, held, seen, n0, i, g;
        rst = 1'b1;
        drive(1'b0, 4'h0, 1'b0, '0, '0, '0, '0);
        leak_factor = 16'h0040; inv_batch_x2 = 16'h0200;
        out_ready = 1'b1; flag_clr = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_count", h_cache_count, '0);
        chk("rst_ovf", h_cache_ovf, 1'b0);
        chk("rst_unf", h_cache_unf, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // forward pass: latency and values
        send(4'b1100, 1'b0, {16'h0100, 16'hFF00}, {16'h0100, 16'h0080}, '0, '0);
        wait_out(lat);
        chk("fwd_latency", lat, 4);
        chk("fwd_lane0", out_data[15:0], 16'hFFE0);
        chk("fwd_lane1", out_data[31:16], 16'h0200);
        idle(3);

        // transition pass writes one cache entry
        send(4'b1111, 1'b0, {16'hFF00, 16'h0100}, '0, {16'h0000, 16'h0080}, '0);
        wait_out(lat);
        chk("trans_lane0", out_data[15:0], 16'h0100);
        chk("trans_lane1", out_data[31:16], 16'hFFE0);
        chk("trans_count", h_cache_count, CACHE ? 1 : 0);
        idle(3);

        // saturation at both rails
        send(4'b1000, 1'b0, {16'h8000, 16'h7F00}, {16'hFF00, 16'h7F00}, '0, '0);
        wait_out(lat);
        chk("sat_lane0", out_data[15:0], 16'h7FFF);
        chk("sat_lane1", out_data[31:16], 16'h8000);
        idle(3);

        // backpressure: 20 counting beats, out_ready low for 10 cycles
        n0 = n_out;
        i = 0;
        g = 0;
        out_ready = 1'b0;
        while (in_ready && g < 20) begin
            drive(1'b1, 4'h0, 1'b0, {16'(i + 1000), 16'(i)}, '0, '0, '0);
            tick();
            if (last_acc) i++;
            g++;
        end
        held = i;
        chk("bp_held", held, 5);
        while (g < 10) begin
            tick();
            chk("bp_stall_ready", in_ready, 1'b0);
            g++;
        end
        out_ready = 1'b1;
        g = 0;
        while (i < 20 && g < 100) begin
            drive(1'b1, 4'h0, 1'b0, {16'(i + 1000), 16'(i)}, '0, '0, '0);
            tick();
            if (last_acc) i++;
            g++;
        end
        idle(8);
        chk("bp_out_count", n_out - n0, 20);

        // H cache reads in FIFO order, then an underflow
        do_reset();
        send(4'b1111, 1'b0, {16'hFF00, 16'h0100}, '0, '0, '0);
        send(4'b1111, 1'b0, {16'h0100, 16'hFF00}, '0, '0, '0);
        send(4'b1111, 1'b0, {16'h0200, 16'h0080}, '0, '0, '0);
        idle(6);
        send(4'b0001, 1'b1, {16'h0100, 16'h0100}, '0, '0, '0);
        wait_out(lat);
        chk("bwd_0", out_data, CACHE ? 32'h0040_0100 : 32'h0040_0040);
        send(4'b0001, 1'b1, {16'h0100, 16'h0100}, '0, '0, '0);
        wait_out(lat);
        chk("bwd_1", out_data, CACHE ? 32'h0100_0040 : 32'h0040_0040);
        send(4'b0001, 1'b1, {16'h0100, 16'h0100}, '0, '0, '0);
        wait_out(lat);
        chk("bwd_2", out_data, CACHE ? 32'h0100_0100 : 32'h0040_0040);
        send(4'b0001, 1'b1, {16'h0100, 16'h0100}, '0, '0, '0);
        wait_out(lat);
        chk("bwd_3_empty", out_data, 32'h0040_0040);
        chk("bwd_unf", h_cache_unf, CACHE);
        idle(3);

        // overflow, then clear both flags
        for (int k = 0; k < H_DEPTH + 1; k++)
            send(4'b1111, 1'b0, {16'(k * 16), 16'(k * 32)}, '0, '0, '0);
        idle(6);
        chk("ovf_set", h_cache_ovf, CACHE);
        chk("ovf_count", h_cache_count, CACHE ? H_DEPTH : 0);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk("clr_ovf", h_cache_ovf, 1'b0);
        chk("clr_unf", h_cache_unf, 1'b0);

        // reset with three beats in flight
        drive(1'b1, 4'b1100, 1'b0, 32'h1234_5678, '0, '0, '0);
        repeat (3) tick();
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_count", h_cache_count, '0);
        model_reset();
        tick();
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            seen += int'(out_valid);
        end
        chk("midrst_no_emerge", seen, 0);

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom),
                  1'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            leak_factor  = ($urandom_range(0, 1) == 0) ? 16'h0040 : 16'($urandom);
            inv_batch_x2 = ($urandom_range(0, 1) == 0) ? 16'h0200 : 16'($urandom);
            out_ready    = $urandom_range(0, 3) != 0;
            flag_clr     = $urandom_range(0, 19) == 0;
            tick();
        end
        flag_clr = 1'b0;
        out_ready = 1'b1;
        idle(10);
        chk("io_balance", n_out, n_acc);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/vpu_pipe.md
# vpu_pipe

Parametrised, fully pipelined successor to the two-lane vector processing unit. It sits between the systolic array outputs and the unified buffer. It applies a per-beat selectable chain of bias, leaky ReLU, loss gradient and leaky-ReLU derivative across `LANES` fixed-point lanes, with a valid/ready handshake on both sides. An optional H cache stores activations produced during the transition pass so that a later backward pass can consume them without re-fetching from the buffer.

## Interface
- `LANES`, 2: number of parallel lanes.
- `DATA_W`, 16: signed fixed-point word width.
- `FRAC_W`, 8: fractional bits (default Q8.8).
- `H_DEPTH`, 8: H cache depth in beats; must be a power of two, ≥ 2.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: input beat accepted when `in_valid` && `in_ready`.
- `in_pathway` in 4: {bias, lr, loss, lrd} stage enables for this beat.
- `in_h_sel` in 1: 1 = lrd takes H from the H cache, 0 = from `in_h`.
- `in_data` in LANES*DATA_W: systolic array outputs, lane 0 in the LSBs.
- `in_bias` in LANES*DATA_W: per-lane bias scalars.
- `in_y` in LANES*DATA_W: per-lane targets.
- `in_h` in LANES*DATA_W: per-lane H values from the unified buffer.
- `leak_factor` in DATA_W: leak slope, sampled with each beat.
- `inv_batch_x2` in DATA_W: 2/N, sampled with each beat.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts the output beat.
- `out_data` out LANES*DATA_W: result lanes.
- `h_cache_count` out $clog2(H_DEPTH)+1: number of occupied cache entries.
- `h_cache_ovf` out 1: sticky flag, cache write dropped because the cache was full.
- `h_cache_unf` out 1: sticky flag, cache read attempted while the cache was empty.
- `flag_clr` in 1: synchronous clear of both sticky flags.

## Operation
- Four register stages, S1 bias, S2 lr, S3 loss, S4 lrd, plus the output register. Each beat carries its own pathway, sideband operands and H through the pipe. The pathway may change on any beat.
- **Disabled stage:** the value passes unchanged but is still registered, so latency is fixed.
- **S1 (bias):** z = sat(x + b).
- **S2 (leaky ReLU):** h = z if z ≥ 0, else sat((z*leak) >>> FRAC_W).
- **S3 (loss gradient):** g = sat((sat(h − y) * inv_batch_x2) >>> FRAC_W).
- **S4 (leaky-ReLU derivative):** d_out = d if H > 0, else sat((d*leak) >>> FRAC_W). The H used depends on the loss bit:
  - loss bit set: the S2 result of the same beat.
  - loss bit clear: the sideband H, from `in_h` or from the cache per `in_h_sel`.
- **Arithmetic:**
  - Products are full 2*DATA_W wide.
  - The right shift is arithmetic (floor).
  - `sat` clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - No wrap-around anywhere.
- **H cache write:** for a beat with pathway 1111, the S2 results of all lanes are pushed as one entry when the beat leaves S2.
  - Full cache: the write is dropped and `h_cache_ovf` is set.
- **H cache read:** a beat accepted with `in_h_sel`=1 and loss bit 0 pops one entry at acceptance.
  - Empty cache: H = 0 for all lanes and `h_cache_unf` is set.
  - Simultaneous push and pop: the count is unchanged. The pop returns the oldest entry; with the cache empty, the pop underflows and the push is still stored.
- **Flags:** sticky until `flag_clr`. If `flag_clr` coincides with a new event, the flag stays set.

## Timing
- **Latency:** a beat accepted at edge k appears with `out_valid` after edge k+4 when there are no stalls. Throughput is one beat per cycle.
- **Stall:** the pipe advances when `out_ready` is 1 or `out_valid` is 0; otherwise every stage holds.
  - `in_ready` equals the advance condition (combinational from `out_ready`).
  - Bubbles (invalid stages) are not compacted. `out_valid` is held with `out_data` stable until it is taken.
- **Reset (`rst`=0):** at the asynchronous assertion, and throughout reset:
  - `out_valid`=0, `out_data`=0 and all stage valids are 0.
  - `in_ready`=0.
  - Cache emptied, `h_cache_count`=0, both flags 0.
- **Reset mid-operation:** in-flight beats are discarded and never appear at the output. The first edge after deassertion may accept a beat.

## Configuration
- `VPU_PIPE_H_CACHE_EN` defined: H cache, count and flags are present as above.
- `VPU_PIPE_H_CACHE_EN` undefined:
  - No cache storage.
  - `in_h_sel` is ignored and H always comes from `in_h`.
  - `h_cache_count`=0 and both flags are tied to 0.
  - Latency and handshake are unchanged.

## Test plan
All scenarios use Q8.8 with leak=0x0040 (0.25), `inv_batch_x2`=0x0200 (2.0) and `out_ready`=1 unless noted.
- **Forward pass:** pathway 1100; lane0 x=0xFF00, b=0x0080; lane1 x=0x0100, b=0x0100 -> after 4 cycles lane0=0xFFE0, lane1=0x0200.
- **Transition pass:** pathway 1111; lane0 x=0x0100, b=0, y=0x0080; lane1 x=0xFF00, b=0, y=0 -> lane0=0x0100, lane1=0xFFE0; `h_cache_count`=1.
- **Saturation:** pathway 1000; lane0 x=0x7F00, b=0x7F00; lane1 x=0x8000, b=0xFF00 -> lane0=0x7FFF, lane1=0x8000.
- **Backpressure:** continuous input of 20 counting beats with `out_ready` low for 10 cycles -> `in_ready` drops once 5 beats are held; output is all 20 beats in order, no loss, no duplicates.
- **H cache reads:**
  - 3 transition beats, then 4 backward beats (pathway 0001, `in_h_sel`=1, d=0x0100) -> first 3 use the cached H in FIFO order.
  - 4th backward beat -> H=0, result 0x0040, `h_cache_unf`=1.
  - `H_DEPTH`+1 transition beats -> `h_cache_ovf`=1 and count=`H_DEPTH`.
  - `flag_clr` pulse -> both flags 0.
- **Reset mid-flight:** assert `rst` with 3 beats in flight -> `out_valid`=0 immediately, count=0, and none of the 3 beats emerges after release.
